// File: rtl/wait_qualifier.sv
// Input-qualification timer: flags `in` once it has been sampled high for k_wait consecutive edges.
// Build option WAIT_PULSE_EN turns `waited` into a single pulse per high run instead of a level.
module wait_qualifier #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in,
  input  logic [CNT_W-1:0] k_wait,
  output logic             waited,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] k_eff;
  logic [CNT_W:0]   next_sum;
  logic             reach;
  logic             below;

  // Threshold compare on a widened sum so k_wait at full scale cannot overflow.
  always_comb begin
    k_eff    = (k_wait == '0) ? CNT_W'(1) : k_wait;
    next_sum = {1'b0, count} + (CNT_W + 1)'(1);
    reach    = (next_sum >= {1'b0, k_eff});
    below    = (count < k_eff);
  end

  // Saturating run counter; any low sample restarts it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!in) begin
      count <= '0;
    end else if (below) begin
      count <= count + CNT_W'(1);
    end
  end

`ifdef WAIT_PULSE_EN
  logic fired;

  // Pulse once per high run; fired blocks re-pulsing until in drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      waited <= 1'b0;
      fired  <= 1'b0;
    end else if (!in) begin
      waited <= 1'b0;
      fired  <= 1'b0;
    end else begin
      waited <= reach & ~fired;
      fired  <= fired | reach;
    end
  end
`else
  // Level flag: once qualified it holds until in drops, whatever k_wait does.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      waited <= 1'b0;
    end else if (!in) begin
      waited <= 1'b0;
    end else begin
      waited <= waited | reach;
    end
  end
`endif

endmodule

// File: tb/tb_wait_qualifier.sv
// Directed self-checking bench for wait_qualifier; expectations adapt to the WAIT_PULSE_EN build.
module tb_wait_qualifier;

`ifdef WAIT_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       in;
  logic [7:0] k_wait;
  logic       waited;
  logic [7:0] count;

  int checks;
  int errors;

  wait_qualifier #(.CNT_W(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .in     (in),
    .k_wait (k_wait),
    .waited (waited),
    .count  (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive in, take one rising edge, return at the following falling edge.
  task automatic step(input logic in_v);
    in = in_v;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; in = 1'b0; k_wait = 8'd5;
    @(negedge clock); @(negedge clock);
    checks++;
    if (count !== 8'd0 || waited !== 1'b0) begin
      errors++; $display("FAIL reset_hold count=%0d waited=%0b want 0/0", count, waited);
    end
    reset = 1'b0;
    step(1'b1); step(1'b1);
    checks++;
    if (count !== 8'd2) begin
      errors++; $display("FAIL pre_reset_count count=%0d want 2", count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (count !== 8'd0 || waited !== 1'b0) begin
      errors++; $display("FAIL async_reset count=%0d waited=%0b want 0/0", count, waited);
    end
    @(negedge clock);
    reset = 1'b0;
    step(1'b1);
    checks++;
    if (count !== 8'd1 || waited !== 1'b0) begin
      errors++; $display("FAIL post_reset_edge count=%0d waited=%0b want 1/0", count, waited);
    end
    step(1'b0);
  endtask

  task automatic test_short_run();
    logic [7:0] exp_c [3];
    exp_c[0] = 8'd1; exp_c[1] = 8'd2; exp_c[2] = 8'd0;
    k_wait = 8'd3;
    for (int i = 0; i < 3; i++) begin
      step(i < 2);
      checks++;
      if (count !== exp_c[i] || waited !== 1'b0) begin
        errors++; $display("FAIL short_run edge%0d count=%0d waited=%0b want %0d/0", i + 1, count, waited, exp_c[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] exp_c;
    logic       exp_w;
    k_wait = 8'd3;
    for (int e = 1; e <= 7; e++) begin
      step(e <= 6);
      exp_c = (e == 7) ? 8'd0 : ((e < 3) ? 8'(e) : 8'd3);
      exp_w = (e == 7) ? 1'b0 : (PULSE ? (e == 3) : (e >= 3));
      checks++;
      if (count !== exp_c || waited !== exp_w) begin
        errors++; $display("FAIL hold edge%0d count=%0d waited=%0b want %0d/%0b", e, count, waited, exp_c, exp_w);
      end
    end
  endtask

  task automatic test_min_threshold();
    logic [7:0] kv [2];
    kv[0] = 8'd0; kv[1] = 8'd1;
    for (int j = 0; j < 2; j++) begin
      k_wait = kv[j];
      step(1'b1);
      checks++;
      if (count !== 8'd1 || waited !== 1'b1) begin
        errors++; $display("FAIL min_k k=%0d count=%0d waited=%0b want 1/1", kv[j], count, waited);
      end
      step(1'b0);
      checks++;
      if (count !== 8'd0 || waited !== 1'b0) begin
        errors++; $display("FAIL min_k_clear k=%0d count=%0d waited=%0b want 0/0", kv[j], count, waited);
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] exp_c;
    logic       exp_w;
    k_wait = 8'd255;
    for (int e = 1; e <= 300; e++) begin
      step(1'b1);
      exp_c = (e >= 255) ? 8'd255 : 8'(e);
      exp_w = PULSE ? (e == 255) : (e >= 255);
      checks++;
      if (count !== exp_c || waited !== exp_w) begin
        errors++; $display("FAIL saturate edge%0d count=%0d waited=%0b want %0d/%0b", e, count, waited, exp_c, exp_w);
      end
    end
    step(1'b0);
  endtask

  task automatic test_k_change();
    logic [7:0] exp_c [8];
    logic       exp_w;
    exp_c[1] = 8'd1; exp_c[2] = 8'd2; exp_c[3] = 8'd3; exp_c[4] = 8'd3;
    exp_c[5] = 8'd4; exp_c[6] = 8'd5; exp_c[7] = 8'd5;
    k_wait = 8'd5;
    for (int e = 1; e <= 7; e++) begin
      if (e == 4) k_wait = 8'd2;
      if (e == 5) k_wait = 8'd5;
      step(1'b1);
      exp_w = PULSE ? (e == 4) : (e >= 4);
      checks++;
      if (count !== exp_c[e] || waited !== exp_w) begin
        errors++; $display("FAIL k_change edge%0d count=%0d waited=%0b want %0d/%0b", e, count, waited, exp_c[e], exp_w);
      end
    end
    step(1'b0);
    checks++;
    if (count !== 8'd0 || waited !== 1'b0) begin
      errors++; $display("FAIL k_change_clear count=%0d waited=%0b want 0/0", count, waited);
    end
  endtask

  task automatic test_back_to_back();
    k_wait = 8'd2;
    step(1'b1); step(1'b1);
    step(1'b0);
    step(1'b1);
    checks++;
    if (count !== 8'd1 || waited !== 1'b0) begin
      errors++; $display("FAIL glitch_restart count=%0d waited=%0b want 1/0", count, waited);
    end
    step(1'b1);
    checks++;
    if (count !== 8'd2 || waited !== 1'b1) begin
      errors++; $display("FAIL requalify count=%0d waited=%0b want 2/1", count, waited);
    end
    step(1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_short_run();
    test_hold();
    test_min_threshold();
    test_saturate();
    test_k_change();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wait_qualifier.md
Name: wait_qualifier

Overview:
- Input-qualification timer: asserts `waited` once `in` has been sampled high for `k_wait` consecutive rising clock edges.
- Any low sample of `in` restarts qualification.
- Used in the vending controller to debounce and confirm held user or coin inputs before the FSM acts on them.
- Purely synchronous counting; one clock domain.

Parameters:
- CNT_W, 8, width of `k_wait` and of the internal and visible counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  1  level to qualify; must already be synchronous to `clock`, with no internal synchronizer.
- k_wait  input  CNT_W  required number of consecutive high samples; sampled live each cycle.
- waited  output  1  registered qualification flag.
- count  output  CNT_W  registered progress counter: current consecutive-high sample count, saturating.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset (async, any time, including mid-count):
  - count = 0 and waited = 0 immediately.
  - Both outputs hold while reset is high.
  - First update occurs on the first rising edge after reset deasserts.
- Effective threshold: K = (k_wait == 0) ? 1 : k_wait. k_wait = 0 is treated as 1.
- On each rising edge with reset low:
  - in == 0: count <= 0; waited <= 0. Deassertion is one edge after the low sample.
  - in == 1 and count < K: count <= count + 1.
  - in == 1 and count >= K: count holds. No wrap; count never exceeds 2^CNT_W-1 and never exceeds max(count, K).
  - waited <= 1 when in == 1 and (count + 1 >= K), i.e. on the K-th consecutive high edge. The compare uses a CNT_W+1-bit sum, so there is no overflow at k_wait = 255.
- Latency:
  - waited rises on the same edge that registers the K-th high sample.
  - With in high before edge 1, waited is visible after edge K.
- waited stays 1 while in remains high (level mode), regardless of later k_wait changes.
- k_wait change mid-qualification:
  - The new value applies from the next edge.
  - If count already >= the new K and in == 1, waited asserts on the next edge.
  - Lowering k_wait never clears waited.
  - Raising k_wait while waited == 1 does not clear it either; only in == 0 or reset clears it.
- Glitch of in low for a single sample: full restart; count returns to 0.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: WAIT_PULSE_EN.
- Defined:
  - waited is a single-cycle pulse, high only on the edge where the qualification threshold is first met within the current high run.
  - An internal "fired" flag suppresses re-pulsing until in is sampled low or reset occurs.
  - count behaviour is unchanged.
  - A k_wait decrease after firing produces no second pulse.
- Not defined: level behaviour as in Behaviour.

Test Plan:
1. Reset asserted asynchronously mid-cycle with count = 2 -> count = 0 and waited = 0 immediately, before the next edge. After release, the first edge with in = 1 gives count = 1.
2. k_wait = 3, in high for 2 edges then low -> count goes 1, 2, 0; waited stays 0 throughout.
3. k_wait = 3, in held high for 6 edges then low -> count 1, 2, 3, 3, 3, 3 and waited = 1 from edge 3 to edge 6. Edge 7 (in = 0) gives waited = 0, count = 0. With WAIT_PULSE_EN, waited = 1 only after edge 3.
4. k_wait = 0 and k_wait = 1, in high for one edge -> waited = 1 after edge 1 in both cases.
5. k_wait = 255, in high for 300 edges -> waited rises after edge 255; count saturates at 255 with no wrap.
6. k_wait = 5, in high; after edge 3 change k_wait to 2 -> waited = 1 after edge 4. Then change k_wait back to 5 -> waited stays 1 until in goes low.
